// File: rtl/pcm_buffer_writer_if.sv
// Decoder-to-buffer sample handshake.
//   sample_valid : decoder offers a stereo pair
//   sample_ready : buffer writer accepts the pair this cycle
//   ch0_sample   : left sample
//   ch1_sample   : right sample
// master = decoder side, slave = pcm_buffer_writer side.
interface pcm_buffer_writer_if;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] ch0_sample;
  logic [15:0] ch1_sample;

  modport master (
    output sample_valid,
    output ch0_sample,
    output ch1_sample,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  ch0_sample,
    input  ch1_sample,
    output sample_ready
  );
endinterface

// File: rtl/pcm_buffer_writer.sv
// Producer-side controller for the stereo PCM buffer drained by the AC97 path.
// Accepts decoded sample pairs, writes them into the PCM RAM write port,
// tracks occupancy against the consumer read pointer and gates the consumer's
// read advance with a prime/run state machine.
// Ports:
//   CLOCK_I, RESET_I        : clock, synchronous active-high reset
//   sample_if (slave)       : valid/ready sample-pair handshake from the decoder
//   FLUSH_I                 : discard buffered samples
//   DRAIN_I                 : end of stream, play out below the watermark
//   PCM_READ_ADDRESS_I      : consumer read pointer
//   PCM_READ_ADVANCE_EN_O   : consumer may advance (combinational)
//   PCM_WRITE_EN_O/ADDRESS_O, CH0/CH1_PCM_DATA_O : registered RAM write port
//   FILL_LEVEL_O            : registered occupancy
//   UNDERRUN_O              : one-cycle pulse on RUN->PRIME underrun
module pcm_buffer_writer #(
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned LOW_WATERMARK = 64
) (
  input  logic                  CLOCK_I,
  input  logic                  RESET_I,
  pcm_buffer_writer_if.slave    sample_if,
  input  logic                  FLUSH_I,
  input  logic                  DRAIN_I,
  input  logic [ADDR_WIDTH-1:0] PCM_READ_ADDRESS_I,
  output logic                  PCM_READ_ADVANCE_EN_O,
  output logic                  PCM_WRITE_EN_O,
  output logic [ADDR_WIDTH-1:0] PCM_WRITE_ADDRESS_O,
  output logic [15:0]           CH0_PCM_DATA_O,
  output logic [15:0]           CH1_PCM_DATA_O,
  output logic [ADDR_WIDTH-1:0] FILL_LEVEL_O,
  output logic                  UNDERRUN_O
);

  localparam int unsigned SAMPLE_W = 16;
  localparam logic [ADDR_WIDTH-1:0] FILL_FULL = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] FILL_LOW  = ADDR_WIDTH'(LOW_WATERMARK);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic                  wr_en_q, wr_en_d;
  logic                  underrun_q, underrun_d;
  logic [SAMPLE_W-1:0]   ch0_q, ch0_d;
  logic [SAMPLE_W-1:0]   ch1_q, ch1_d;

  logic [ADDR_WIDTH-1:0] fill_c;
  logic                  full_c, empty_c, ready_c, xfer_c;

  // Occupancy from the live pointers; modular subtraction handles wrap.
  assign fill_c  = wp_q - PCM_READ_ADDRESS_I;
  assign full_c  = (fill_c == FILL_FULL);
  assign empty_c = (fill_c == '0);
  assign ready_c = !RESET_I && !FLUSH_I && !full_c;
  assign xfer_c  = sample_if.sample_valid && ready_c;

  assign sample_if.sample_ready = ready_c;
  assign PCM_READ_ADVANCE_EN_O  = !RESET_I && !FLUSH_I && (state_q == ST_RUN) && !empty_c;

  assign PCM_WRITE_EN_O      = wr_en_q;
  assign PCM_WRITE_ADDRESS_O = wr_addr_q;
  assign CH0_PCM_DATA_O      = ch0_q;
  assign CH1_PCM_DATA_O      = ch1_q;
  assign FILL_LEVEL_O        = fill_q;
  assign UNDERRUN_O          = underrun_q;

  // Next-state: write capture, pointer update, prime/run control.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    wr_addr_d  = wr_addr_q;
    ch0_d      = ch0_q;
    ch1_d      = ch1_q;
    wr_en_d    = 1'b0;
    underrun_d = 1'b0;
    fill_d     = fill_c;

    if (FLUSH_I) begin
      // Collapse the buffer onto the consumer pointer; any offered pair is dropped.
      wp_d    = PCM_READ_ADDRESS_I;
      state_d = ST_PRIME;
      fill_d  = '0;
    end else begin
      if (xfer_c) begin
        wr_en_d   = 1'b1;
        wr_addr_d = wp_q;
        ch0_d     = sample_if.ch0_sample;
        ch1_d     = sample_if.ch1_sample;
        wp_d      = wp_q + ADDR_WIDTH'(1);
      end

      unique case (state_q)
        ST_PRIME: begin
          if ((fill_c >= FILL_LOW) || (DRAIN_I && !empty_c)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // While draining, an empty buffer is the expected end, not an underrun.
          if (empty_c && !DRAIN_I) begin
            state_d    = ST_PRIME;
            underrun_d = 1'b1;
          end
        end
        default: state_d = ST_PRIME;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_I) begin
    if (RESET_I) begin
      state_q    <= ST_PRIME;
      wp_q       <= '0;
      wr_addr_q  <= '0;
      ch0_q      <= '0;
      ch1_q      <= '0;
      wr_en_q    <= 1'b0;
      underrun_q <= 1'b0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      wr_addr_q  <= wr_addr_d;
      ch0_q      <= ch0_d;
      ch1_q      <= ch1_d;
      wr_en_q    <= wr_en_d;
      underrun_q <= underrun_d;
      fill_q     <= fill_d;
    end
  end

endmodule

// File: tb/tb_pcm_buffer_writer.sv
// Self-checking bench for pcm_buffer_writer: directed sequences, a vector
// table for the underrun corner, and randomized traffic against a reference model.
module tb_pcm_buffer_writer;
  localparam int unsigned AW    = 9;
  localparam int          DEPTH = 512;
  localparam int          LW    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i, drain_i;
  logic [AW-1:0] rd_addr;
  logic          adv_en, wr_en, underrun;
  logic [AW-1:0] wr_addr, fill;
  logic [15:0]   d0_o, d1_o;

  always #5 clk = ~clk;

  pcm_buffer_writer_if sif ();

  pcm_buffer_writer #(.ADDR_WIDTH(AW), .LOW_WATERMARK(LW)) dut (
    .CLOCK_I               (clk),
    .RESET_I               (rst),
    .sample_if             (sif),
    .FLUSH_I               (flush_i),
    .DRAIN_I               (drain_i),
    .PCM_READ_ADDRESS_I    (rd_addr),
    .PCM_READ_ADVANCE_EN_O (adv_en),
    .PCM_WRITE_EN_O        (wr_en),
    .PCM_WRITE_ADDRESS_O   (wr_addr),
    .CH0_PCM_DATA_O        (d0_o),
    .CH1_PCM_DATA_O        (d1_o),
    .FILL_LEVEL_O          (fill),
    .UNDERRUN_O            (underrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffer as two integer pointers plus a playing flag.
  int          m_wp, rd_v;
  bit          m_run;
  bit          e_wr_en, e_under;
  int          e_fill, e_addr;
  logic [15:0] e_ch0, e_ch1;

  // Values observed in the most recent cycle.
  bit obs_ready, obs_adv, obs_wr_en, obs_under;
  int obs_fill, obs_addr;

  typedef struct {
    bit valid; bit flush; bit drain; bit consume;
    bit exp_ready; bit exp_adv; bit exp_wr_en; bit exp_under; int exp_fill;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, advance the model,
  // check registered outputs after the edge, then let the consumer step.
  task automatic cycle(input bit valid, input bit flsh, input bit drn, input bit consume);
    logic [15:0] d0, d1;
    int mfill;
    bit e_ready, e_adv, xfer;
    d0 = 16'($urandom);
    d1 = 16'($urandom);
    @(negedge clk);
    rst = 1'b0;
    sif.sample_valid = valid;
    sif.ch0_sample = d0;
    sif.ch1_sample = d1;
    flush_i = flsh;
    drain_i = drn;
    rd_addr = AW'(rd_v);
    #1;
    mfill   = (m_wp - rd_v + DEPTH) % DEPTH;
    e_ready = !flsh && (mfill != DEPTH - 1);
    e_adv   = m_run && (mfill != 0) && !flsh;
    obs_ready = sif.sample_ready;
    obs_adv   = adv_en;
    check("ready", int'(obs_ready), int'(e_ready));
    check("advance", int'(obs_adv), int'(e_adv));
    xfer = valid && e_ready;
    if (flsh) begin
      m_wp = rd_v; m_run = 1'b0; e_wr_en = 1'b0; e_fill = 0; e_under = 1'b0;
    end else begin
      e_fill = mfill; e_under = 1'b0; e_wr_en = xfer;
      if (xfer) begin
        e_addr = m_wp; e_ch0 = d0; e_ch1 = d1;
        m_wp = (m_wp + 1) % DEPTH;
      end
      if (!m_run) m_run = (mfill >= LW) || (drn && mfill != 0);
      else if (mfill == 0 && !drn) begin
        m_run = 1'b0; e_under = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    obs_wr_en = wr_en;
    obs_fill  = int'(fill);
    obs_under = underrun;
    obs_addr  = int'(wr_addr);
    check("write_en", int'(obs_wr_en), int'(e_wr_en));
    check("fill_level", obs_fill, e_fill);
    check("underrun", int'(obs_under), int'(e_under));
    if (e_wr_en) begin
      check("write_addr", obs_addr, e_addr);
      check("ch0_data", int'(d0_o), int'(e_ch0));
      check("ch1_data", int'(d1_o), int'(e_ch1));
    end
    if (consume && e_adv) rd_v = (rd_v + 1) % DEPTH;
  endtask

  // Reset with a pair offered: handshake and advance must stay low, registers clear.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sif.sample_valid = 1'b1;
    flush_i = 1'b0;
    drain_i = 1'b0;
    rd_v = 0;
    rd_addr = '0;
    #1;
    check("reset_ready", int'(sif.sample_ready), 0);
    check("reset_advance", int'(adv_en), 0);
    @(posedge clk);
    #1;
    check("reset_write_en", int'(wr_en), 0);
    check("reset_write_addr", int'(wr_addr), 0);
    check("reset_ch0", int'(d0_o), 0);
    check("reset_ch1", int'(d1_o), 0);
    check("reset_fill", int'(fill), 0);
    check("reset_underrun", int'(underrun), 0);
    m_wp = 0; m_run = 1'b0;
  endtask

  task automatic fill_pairs(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic consume_to(input int target);
    int n;
    n = 0;
    while (rd_v != target && n < 1000) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    check("consume_reach", rd_v, target);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int acc, last_addr, adv_cnt, und_cnt;
    bit v, c, f, d;
    int pv, pc;

    // RUN at fill 3 draining to empty with DRAIN low: underrun then PRIME.
    vecs[0] = '{0, 0, 0, 1, 1, 1, 0, 0, 3};
    vecs[1] = '{0, 0, 0, 1, 1, 1, 0, 0, 2};
    vecs[2] = '{0, 0, 0, 1, 1, 1, 0, 0, 1};
    vecs[3] = '{0, 0, 0, 1, 1, 0, 0, 1, 0};
    vecs[4] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};

    rst = 1'b1; flush_i = 1'b0; drain_i = 1'b0; rd_addr = '0;
    sif.sample_valid = 1'b0; sif.ch0_sample = '0; sif.ch1_sample = '0;
    m_wp = 0; rd_v = 0; m_run = 1'b0;
    e_addr = 0; e_ch0 = '0; e_ch1 = '0;

    // Prime with 64 pairs, rd held at 0.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("prime_addr", obs_addr, i);
      check("prime_adv_low", int'(obs_adv), 0);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("prime_adv_before_run", int'(obs_adv), 0);
    check("prime_fill_64", obs_fill, 64);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("run_adv_high", int'(obs_adv), 1);

    // Fill to capacity, then one consumer step admits exactly one more pair.
    do_reset();
    acc = 0;
    for (int i = 0; i < 600; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (obs_ready) acc++;
    end
    check("full_accepted", acc, 511);
    check("full_ready_low", int'(obs_ready), 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    acc = 0; last_addr = -1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (obs_ready) acc++;
      if (obs_wr_en) last_addr = obs_addr;
    end
    check("wrap_accepted", acc, 1);
    check("wrap_addr", last_addr, 511);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_fill", obs_fill, 511);

    // Underrun corner from the vector table, then refill resumes playback.
    do_reset();
    fill_pairs(64);
    consume_to(61);
    for (int i = 0; i < 5; i++) begin
      cycle(vecs[i].valid, vecs[i].flush, vecs[i].drain, vecs[i].consume);
      check($sformatf("tbl%0d_ready", i), int'(obs_ready), int'(vecs[i].exp_ready));
      check($sformatf("tbl%0d_adv", i), int'(obs_adv), int'(vecs[i].exp_adv));
      check($sformatf("tbl%0d_wr_en", i), int'(obs_wr_en), int'(vecs[i].exp_wr_en));
      check($sformatf("tbl%0d_underrun", i), int'(obs_under), int'(vecs[i].exp_under));
      check($sformatf("tbl%0d_fill", i), obs_fill, vecs[i].exp_fill);
    end
    fill_pairs(63);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("refill_still_prime", int'(obs_adv), 0);
    fill_pairs(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("refill_resume_adv", int'(obs_adv), 1);

    // Drain below the watermark: play out 10 pairs without an underrun.
    do_reset();
    fill_pairs(10);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("drain_below_wm_adv", int'(obs_adv), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    adv_cnt = 0; und_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      if (obs_adv) adv_cnt++;
      if (obs_under) und_cnt++;
    end
    check("drain_adv_count", adv_cnt, 10);
    check("drain_no_underrun", und_cnt, 0);
    check("drain_empty_adv", int'(obs_adv), 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("drain_release_underrun", int'(obs_under), 1);

    // Flush with a simultaneous valid at fill 100, rd 37.
    do_reset();
    fill_pairs(137);
    consume_to(37);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("flush_ready", int'(obs_ready), 0);
    check("flush_no_write", int'(obs_wr_en), 0);
    check("flush_fill", obs_fill, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("flush_prime_adv", int'(obs_adv), 0);
    check("flush_fill_hold", obs_fill, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("flush_next_addr", obs_addr, 37);

    // Write and consume in the same cycle at fill 64.
    do_reset();
    fill_pairs(64);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      check("steady_adv", int'(obs_adv), 1);
      check("steady_fill", obs_fill, 64);
    end
    check("steady_last_addr", obs_addr, 71);

    // Randomized traffic in phases of varying producer/consumer rates.
    do_reset();
    pv = 2; pc = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        pv = $urandom_range(0, 4);
        pc = $urandom_range(0, 4);
        d  = ($urandom_range(0, 3) == 0);
      end
      if (i == 2000) do_reset();
      v = ($urandom_range(0, 3) < pv);
      c = ($urandom_range(0, 3) < pc);
      f = ($urandom_range(0, 299) == 0);
      cycle(v, f, d, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
